// File: rtl/plmem_lsu_if.sv
// Data-memory bus between the MEM-stage load/store unit and the data memory.
// Single outstanding request: the master raises req with we/addr/be/wdata and
// holds them until the slave answers with ack. For reads, rdata is valid in
// the ack cycle.
//   req    master->slave  request valid, held until ack
//   we     master->slave  1 = write
//   addr   master->slave  word-aligned byte address
//   be     master->slave  byte enables, bit i = byte lane i (little-endian)
//   wdata  master->slave  lane-replicated store data
//   ack    slave->master  write accepted / read data returned this cycle
//   rdata  slave->master  read data, valid with ack
interface plmem_lsu_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, we, addr, be, wdata, input ack, rdata);
    modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/plmem_lsu.sv
// plmem_lsu: memory-stage load/store unit of the pipelined CPU.
// Takes the effective address (malu), store data (mb) and writeback controls
// from EXE/MEM, performs one data-memory access at a time over the dmem bus,
// stalls the pipeline while the access is in flight and returns the aligned,
// extended load result on mmo.
//   clock, reset  clock and synchronous active-high reset
//   mvalid        MEM-stage instruction is valid
//   mm2reg/mwmem  load / store
//   mwreg         instruction writes a register
//   msize, msext  access size (00 word, 01 half, 10 byte, 11 word), sign-extend
//   malu, mb      effective byte address, store data
//   dmem          data-memory bus (master side)
//   mmo           load result for MEM/WB
//   mstall        hold PC, IF/ID, ID/EXE, EXE/MEM
//   mwreg_out     mwreg qualified by the error flags
//   maddr_err     misaligned access (combinational pulse in IDLE)
//   mbus_err      ack timeout (registered pulse in DONE)
module plmem_lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mvalid,
    input  logic        mm2reg,
    input  logic        mwmem,
    input  logic        mwreg,
    input  logic [1:0]  msize,
    input  logic        msext,
    input  logic [31:0] malu,
    input  logic [31:0] mb,
    plmem_lsu_if.master dmem,
    output logic [31:0] mmo,
    output logic        mstall,
    output logic        mwreg_out,
    output logic        maddr_err,
    output logic        mbus_err
);
    localparam int CW = $clog2(TIMEOUT + 1);
    // The timeout fires in the REQ cycle where the counter would reach TIMEOUT,
    // so exactly TIMEOUT REQ cycles are spent without an ack.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t         state_reg, state_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic           req_reg, req_next;
    logic           we_reg, we_next;
    logic [31:0]    addr_reg, addr_next;
    logic [3:0]     be_reg, be_next;
    logic [31:0]    wdata_reg, wdata_next;
    logic [1:0]     size_reg, size_next;
    logic [1:0]     lane_reg, lane_next;
    logic           sext_reg, sext_next;
    logic [31:0]    mmo_reg, mmo_next;
    logic           berr_reg, berr_next;

    // Request decode on the live EXE/MEM inputs
    logic        is_mem, is_half, is_byte, is_word, aligned, start;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;

    assign is_mem  = mvalid & (mm2reg | mwmem);
    assign is_half = (msize == 2'b01);
    assign is_byte = (msize == 2'b10);
    assign is_word = ~is_half & ~is_byte;
    assign aligned = is_byte | (is_half & ~malu[0]) | (is_word & (malu[1:0] == 2'b00));
    assign start   = is_mem & aligned;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        assign be_calc[gi] = is_word
                           | (is_half & (malu[1] == LANE[1]))
                           | (is_byte & (malu[1:0] == LANE));
    end

    assign wdata_calc = is_byte ? {4{mb[7:0]}} :
                        is_half ? {2{mb[15:0]}} : mb;

    // Load extraction uses the latched size/lane, not the live inputs
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;

    always_comb begin
        byte_sel = dmem.rdata[7:0];
        case (lane_reg)
            2'd1:    byte_sel = dmem.rdata[15:8];
            2'd2:    byte_sel = dmem.rdata[23:16];
            2'd3:    byte_sel = dmem.rdata[31:24];
            default: byte_sel = dmem.rdata[7:0];
        endcase
        half_sel = lane_reg[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
        case (size_reg)
            2'b01:   load_val = {{16{sext_reg & half_sel[15]}}, half_sel};
            2'b10:   load_val = {{24{sext_reg & byte_sel[7]}}, byte_sel};
            default: load_val = dmem.rdata;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        req_next   = req_reg;
        we_next    = we_reg;
        addr_next  = addr_reg;
        be_next    = be_reg;
        wdata_next = wdata_reg;
        size_next  = size_reg;
        lane_next  = lane_reg;
        sext_next  = sext_reg;
        mmo_next   = 32'h0;
        berr_next  = 1'b0;
        mstall     = 1'b0;
        maddr_err  = 1'b0;

        case (state_reg)
            IDLE: begin
                maddr_err = is_mem & ~aligned;
                mstall    = start;
                if (start) begin
                    state_next = REQ;
                    cnt_next   = '0;
                    req_next   = 1'b1;
                    we_next    = mwmem;
                    addr_next  = {malu[31:2], 2'b00};
                    be_next    = be_calc;
                    wdata_next = wdata_calc;
                    size_next  = msize;
                    lane_next  = malu[1:0];
                    sext_next  = msext;
                end
            end
            REQ: begin
                mstall = 1'b1;
                if (dmem.ack) begin
                    state_next = DONE;
                    req_next   = 1'b0;
                    mmo_next   = we_reg ? 32'h0 : load_val;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = DONE;
                    req_next   = 1'b0;
                    cnt_next   = cnt_reg + 1'b1;
                    berr_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                req_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            req_reg   <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= 32'h0;
            be_reg    <= 4'h0;
            wdata_reg <= 32'h0;
            size_reg  <= 2'b00;
            lane_reg  <= 2'b00;
            sext_reg  <= 1'b0;
            mmo_reg   <= 32'h0;
            berr_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            req_reg   <= req_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            be_reg    <= be_next;
            wdata_reg <= wdata_next;
            size_reg  <= size_next;
            lane_reg  <= lane_next;
            sext_reg  <= sext_next;
            mmo_reg   <= mmo_next;
            berr_reg  <= berr_next;
        end
    end

    assign dmem.req   = req_reg;
    assign dmem.we    = we_reg;
    assign dmem.addr  = addr_reg;
    assign dmem.be    = be_reg;
    assign dmem.wdata = wdata_reg;
    assign mmo        = mmo_reg;
    assign mbus_err   = berr_reg;
    assign mwreg_out  = mwreg & ~maddr_err & ~berr_reg;
endmodule

// File: tb/tb_plmem_lsu.sv
// Directed bench for plmem_lsu with a scoreboard of expected access results.
module tb_plmem_lsu;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mvalid = 1'b0, mm2reg = 1'b0, mwmem = 1'b0, mwreg = 1'b0;
    logic [1:0]  msize = 2'b00;
    logic        msext = 1'b0;
    logic [31:0] malu = 32'h0, mb = 32'h0;
    logic [31:0] mmo;
    logic        mstall, mwreg_out, maddr_err, mbus_err;

    plmem_lsu_if dmem ();

    plmem_lsu #(.TIMEOUT(4)) dut (
        .clock(clock), .reset(reset),
        .mvalid(mvalid), .mm2reg(mm2reg), .mwmem(mwmem), .mwreg(mwreg),
        .msize(msize), .msext(msext), .malu(malu), .mb(mb),
        .dmem(dmem.master),
        .mmo(mmo), .mstall(mstall), .mwreg_out(mwreg_out),
        .maddr_err(maddr_err), .mbus_err(mbus_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       tag;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] mmo;
        logic        wreg;
        logic        berr;
        int          stalls;
        int          reqs;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input bit ld, input bit st, input bit wr,
                         input logic [1:0] sz, input bit sx,
                         input logic [31:0] a, input logic [31:0] d);
        mvalid = v; mm2reg = ld; mwmem = st; mwreg = wr;
        msize = sz; msext = sx; malu = a; mb = d;
    endtask

    task automatic bubble();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic push(input string tag, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wdata,
                        input logic [31:0] mmo_e, input logic wreg, input logic berr,
                        input int stalls, input int reqs);
        exp_t e;
        e.tag = tag; e.we = we; e.addr = addr; e.be = be; e.wdata = wdata;
        e.mmo = mmo_e; e.wreg = wreg; e.berr = berr; e.stalls = stalls; e.reqs = reqs;
        sb.push_back(e);
    endtask

    // Runs one aligned access; the memory acks after 'waits' REQ cycles
    // (never if waits exceeds the timeout). Result is compared against the
    // scoreboard head in the DONE cycle.
    task automatic access(input bit ld, input bit st, input bit wr,
                          input logic [1:0] sz, input bit sx,
                          input logic [31:0] a, input logic [31:0] d,
                          input int waits, input logic [31:0] rdata, input bit late_ack);
        int stalls = 0;
        int reqs = 0;
        bit done = 1'b0;
        logic        c_we = 1'b0;
        logic [31:0] c_addr = 32'h0, c_wdata = 32'h0;
        logic [3:0]  c_be = 4'h0;
        exp_t e;
        @(posedge clock); #1;
        drive(1'b1, ld, st, wr, sz, sx, a, d);
        @(negedge clock);
        if (mstall) stalls++;
        for (int c = 0; c < 20 && !done; c++) begin
            @(posedge clock); #1;
            if (dmem.req) begin
                if (reqs == 0) begin
                    c_we = dmem.we; c_addr = dmem.addr; c_be = dmem.be; c_wdata = dmem.wdata;
                end
                dmem.ack = (reqs == waits);
                dmem.rdata = rdata;
                reqs++;
            end else begin
                dmem.ack = late_ack;
                dmem.rdata = rdata;
                done = 1'b1;
            end
            @(negedge clock);
            if (mstall) stalls++;
        end
        if (!done || sb.size() == 0) begin
            chk("access_completed", {31'h0, done}, 32'h1);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_we"}, {31'h0, c_we}, {31'h0, e.we});
            chk({e.tag, "_addr"}, c_addr, e.addr);
            chk({e.tag, "_be"}, {28'h0, c_be}, {28'h0, e.be});
            chk({e.tag, "_wdata"}, c_wdata, e.wdata);
            chk({e.tag, "_mmo"}, mmo, e.mmo);
            chk({e.tag, "_wreg_out"}, {31'h0, mwreg_out}, {31'h0, e.wreg});
            chk({e.tag, "_bus_err"}, {31'h0, mbus_err}, {31'h0, e.berr});
            chk({e.tag, "_stall_cycles"}, stalls, e.stalls);
            chk({e.tag, "_req_cycles"}, reqs, e.reqs);
            $display("txn %s: mmo=%h be=%b stalls=%0d reqs=%0d", e.tag, mmo, c_be, stalls, reqs);
        end
        // Next cycle the stage holds a bubble: nothing in flight, late ack ignored
        @(posedge clock); #1;
        bubble();
        dmem.ack = 1'b0;
        @(negedge clock);
        chk("post_req", {31'h0, dmem.req}, 32'h0);
        chk("post_mmo", mmo, 32'h0);
        chk("post_stall", {31'h0, mstall}, 32'h0);
        chk("post_bus_err", {31'h0, mbus_err}, 32'h0);
    endtask

    task automatic misaligned(input string tag, input bit ld, input bit st,
                              input logic [1:0] sz, input logic [31:0] a);
        @(posedge clock); #1;
        drive(1'b1, ld, st, 1'b1, sz, 1'b0, a, 32'h12345678);
        @(negedge clock);
        chk({tag, "_addr_err"}, {31'h0, maddr_err}, 32'h1);
        chk({tag, "_stall"}, {31'h0, mstall}, 32'h0);
        chk({tag, "_wreg_out"}, {31'h0, mwreg_out}, 32'h0);
        chk({tag, "_mmo"}, mmo, 32'h0);
        @(posedge clock); #1;
        chk({tag, "_no_req"}, {31'h0, dmem.req}, 32'h0);
        bubble();
        @(negedge clock);
        chk({tag, "_err_clear"}, {31'h0, maddr_err}, 32'h0);
        chk({tag, "_still_no_req"}, {31'h0, dmem.req}, 32'h0);
        $display("txn %s: misaligned addr=%h", tag, a);
    endtask

    initial begin
        dmem.ack = 1'b0;
        dmem.rdata = 32'h0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_req", {31'h0, dmem.req}, 32'h0);
        chk("rst_we", {31'h0, dmem.we}, 32'h0);
        chk("rst_addr", dmem.addr, 32'h0);
        chk("rst_be", {28'h0, dmem.be}, 32'h0);
        chk("rst_wdata", dmem.wdata, 32'h0);
        chk("rst_mmo", mmo, 32'h0);
        chk("rst_bus_err", {31'h0, mbus_err}, 32'h0);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_stall", {31'h0, mstall}, 32'h0);
        $display("txn reset: checked");

        push("ld_word", 1'b0, 32'h100, 4'b1111, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 2, 1);
        access(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h100, 32'h0, 0, 32'hDEADBEEF, 1'b0);

        push("ld_byte_sext", 1'b0, 32'h100, 4'b1000, 32'h0, 32'hFFFFFF80, 1'b1, 1'b0, 2, 1);
        access(1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 32'h103, 32'h0, 0, 32'h80123456, 1'b0);

        push("ld_byte_zext", 1'b0, 32'h100, 4'b1000, 32'h0, 32'h00000080, 1'b1, 1'b0, 2, 1);
        access(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h103, 32'h0, 0, 32'h80123456, 1'b0);

        push("st_half", 1'b1, 32'h200, 4'b1100, 32'hABCDABCD, 32'h0, 1'b0, 1'b0, 5, 4);
        access(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 32'h202, 32'h0000ABCD, 3, 32'hFFFFFFFF, 1'b0);

        push("ld_half_sext", 1'b0, 32'h000, 4'b1100, 32'h0, 32'hFFFF8001, 1'b1, 1'b0, 3, 2);
        access(1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 32'h002, 32'h0, 1, 32'h80017FFF, 1'b0);

        push("ld_half_lo", 1'b0, 32'h010, 4'b0011, 32'h0, 32'h00007FFF, 1'b1, 1'b0, 2, 1);
        access(1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 32'h010, 32'h0, 0, 32'h80017FFF, 1'b0);

        push("st_byte", 1'b1, 32'h040, 4'b0010, 32'h5A5A5A5A, 32'h0, 1'b0, 1'b0, 2, 1);
        access(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h041, 32'hFFFFFF5A, 0, 32'h0, 1'b0);

        push("st_size11_word", 1'b1, 32'h080, 4'b1111, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0, 2, 1);
        access(1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 32'h080, 32'hCAFEF00D, 0, 32'h0, 1'b0);

        misaligned("mis_ld_word", 1'b1, 1'b0, 2'b00, 32'h102);
        misaligned("mis_st_half", 1'b0, 1'b1, 2'b01, 32'h201);

        // No ack: 4 REQ cycles then bus error; ack arriving in DONE is ignored
        push("st_timeout", 1'b1, 32'h300, 4'b1111, 32'h11223344, 32'h0, 1'b0, 1'b1, 5, 4);
        access(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h300, 32'h11223344, 99, 32'h0, 1'b1);

        // Ack in the last REQ cycle before timeout resolves as ack
        push("ld_ack_at_limit", 1'b0, 32'h304, 4'b1111, 32'h0, 32'h0BADC0DE, 1'b1, 1'b0, 5, 4);
        access(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h304, 32'h0, 3, 32'h0BADC0DE, 1'b0);

        // Non-memory instruction passes through
        @(posedge clock); #1;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h00000102, 32'h0);
        @(negedge clock);
        chk("alu_stall", {31'h0, mstall}, 32'h0);
        chk("alu_wreg_out", {31'h0, mwreg_out}, 32'h1);
        chk("alu_addr_err", {31'h0, maddr_err}, 32'h0);
        chk("alu_mmo", mmo, 32'h0);
        $display("txn alu_passthrough: wreg_out=%b", mwreg_out);

        // Reset during the second REQ cycle abandons the access
        @(posedge clock); #1;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h400, 32'h0);
        @(posedge clock); #1;
        chk("rstreq_req1", {31'h0, dmem.req}, 32'h1);
        @(posedge clock); #1;
        chk("rstreq_req2", {31'h0, dmem.req}, 32'h1);
        reset = 1'b1;
        bubble();
        @(posedge clock); #1;
        chk("rstreq_req_dropped", {31'h0, dmem.req}, 32'h0);
        reset = 1'b0;
        @(negedge clock);
        chk("rstreq_stall", {31'h0, mstall}, 32'h0);
        chk("rstreq_mmo", mmo, 32'h0);
        $display("txn reset_in_req: req=%b", dmem.req);

        push("ld_after_reset", 1'b0, 32'h500, 4'b1111, 32'h0, 32'h600DF00D, 1'b1, 1'b0, 2, 1);
        access(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h500, 32'h0, 0, 32'h600DF00D, 1'b0);

        chk("scoreboard_empty", sb.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
